// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request scheduler: opcodes, the range of
// supported opcodes, and the scheduler FSM encoding.
package cordic_pkg;

    localparam logic [3:0] OP_SIN     = 4'd0;
    localparam logic [3:0] OP_COS     = 4'd1;
    localparam logic [3:0] OP_ATAN    = 4'd2;
    localparam logic [3:0] OP_MAG     = 4'd3;
    localparam logic [3:0] OP_MUL     = 4'd4;
    localparam logic [3:0] OP_DIV     = 4'd5;
    localparam logic [3:0] OP_SINH    = 4'd6;
    localparam logic [3:0] OP_COSH    = 4'd7;
    localparam logic [3:0] OP_ATANH   = 4'd8;
    localparam logic [3:0] OP_MODH    = 4'd9;
    localparam logic [3:0] OP_DEFAULT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    // Opcodes SIN..MODH are implemented by the calc unit; everything above is rejected.
    function automatic logic op_supported(input logic [3:0] op);
        return op <= OP_MODH;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps
// upward; the first requesting index wins. The pointer register is owned by
// the instantiating block.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic found;
    int   idx;

    // Scan from the pointer, wrapping once around, and grant the first requester.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[IW'(idx)]) begin
                found          = 1'b1;
                gnt[IW'(idx)]  = 1'b1;
                gnt_idx        = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one CORDIC calc unit between NUM_REQ requesters: round-robin accept,
// operand latching, enable sequencing with a done/timeout guard, and a
// valid/ready response channel tagged with the requester index.
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [4*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_x,
    input  logic [WIDTH*NUM_REQ-1:0]   req_y,
    input  logic [WIDTH*NUM_REQ-1:0]   req_z,
    output logic                       cu_enable,
    output logic [3:0]                 cu_operation,
    output logic [WIDTH-1:0]           cu_x,
    output logic [WIDTH-1:0]           cu_y,
    output logic [WIDTH-1:0]           cu_z,
    input  logic [WIDTH-1:0]           cu_result,
    input  logic                       cu_done,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    sched_state_e     state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    id_q, id_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic [3:0]         win_op;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign win_op = req_op[int'(gnt_idx) * 4 +: 4];

    // Next-state logic: accept in IDLE, wait for done or timeout in RUN, hold the response in RESP.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    id_d  = gnt_idx;
                    op_d  = win_op;
                    x_d   = req_x[int'(gnt_idx) * WIDTH +: WIDTH];
                    y_d   = req_y[int'(gnt_idx) * WIDTH +: WIDTH];
                    z_d   = req_z[int'(gnt_idx) * WIDTH +: WIDTH];
                    ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d = '0;
                    if (op_supported(win_op)) begin
                        state_d = ST_RUN;
                    end else begin
                        // Rejected opcodes go straight to an error response; the calc unit stays idle.
                        state_d  = ST_RESP;
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (cu_done) begin
                    result_d = cu_result;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; the async reset also discards any pending response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            op_q     <= OP_DEFAULT;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Grants are only visible in IDLE and out of reset; the calc unit sees registered values only.
    assign req_ready    = (state_q == ST_IDLE && rst) ? gnt : '0;
    assign cu_enable    = (state_q == ST_RUN);
    assign cu_operation = op_q;
    assign cu_x         = x_q;
    assign cu_y         = y_q;
    assign cu_z         = z_q;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_id       = id_q;
    assign rsp_result   = result_q;
    assign rsp_err      = err_q;

endmodule
